prbs7_checker: RTL and testbench

PRBS7_CHECKER -- requirements
Module: prbs7_checker

---
 rtl/prbs7_if.sv | 19 +
 rtl/prbs7_checker.sv | 131 +++++++++++++
 tb/tb_prbs7_checker.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/prbs7_if.sv
// ---------------------------------------------------------------------
// prbs7_if : data/control bundle for the PRBS7 checker
// Rev 1.0  initial release
// ---------------------------------------------------------------------
`default_nettype none

interface prbs7_if;
  logic        en;
  logic        din;
  logic        clr_cnt;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_cnt;

  modport master (output en, din, clr_cnt, input locked, err_pulse, err_cnt);
  modport slave  (input en, din, clr_cnt, output locked, err_pulse, err_cnt);
endinterface

`default_nettype wire

// File: rtl/prbs7_checker.sv
// ---------------------------------------------------------------------
// prbs7_checker : x^7+x^6+1 PRBS lock/verify checker with error counter
// Rev 1.0  initial release
// ---------------------------------------------------------------------
`default_nettype none

module prbs7_checker #(
  parameter int unsigned SYNC_LEN    = 16,
  parameter int unsigned LOSS_THRESH = 4
) (
  input  wire     clk,
  input  wire     rst,
  prbs7_if.slave  bus
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [6:0]  sr, sr_n;
  logic [2:0]  fill, fill_n;
  logic [7:0]  match, match_n;
  logic [5:0]  win_pos, win_pos_n;
  logic [6:0]  win_err, win_err_n, win_err_inc;
  logic [15:0] err_cnt, err_cnt_n;
  logic        locked, err_pulse;
  logic        pred, err_hit;

  assign pred          = sr[6] ^ sr[5];
  assign bus.locked    = locked;
  assign bus.err_pulse = err_pulse;
  assign bus.err_cnt   = err_cnt;

  always_comb begin
    state_n     = state;
    sr_n        = sr;
    fill_n      = fill;
    match_n     = match;
    win_pos_n   = win_pos;
    win_err_n   = win_err;
    win_err_inc = win_err;
    err_hit     = 1'b0;
    if (bus.en) begin
      case (state)
        HUNT: begin
          sr_n = {sr[5:0], bus.din};
          if (fill != 3'd7) fill_n = fill + 3'd1;
          // An all-zero history is the LFSR lockup state; keep filling until it breaks
          if (fill_n == 3'd7 && sr_n != 7'd0) begin
            state_n = VERIFY;
            match_n = 8'd0;
          end
        end
        VERIFY: begin
          sr_n = {sr[5:0], bus.din};
          if (bus.din == pred) begin
            if (match == 8'(SYNC_LEN - 1)) begin
              state_n   = LOCK;
              match_n   = 8'd0;
              win_pos_n = 6'd0;
              win_err_n = 7'd0;
            end else begin
              match_n = match + 8'd1;
            end
          end else begin
            state_n = HUNT;
            fill_n  = 3'd1;
            match_n = 8'd0;
          end
        end
        LOCK: begin
          // Self-generated reference keeps received errors out of the history
          sr_n        = {sr[5:0], pred};
          err_hit     = (bus.din != pred);
          win_pos_n   = win_pos + 6'd1;
          win_err_inc = win_err + {6'd0, err_hit};
          if (win_err_inc == 7'(LOSS_THRESH)) begin
            state_n   = HUNT;
            fill_n    = 3'd0;
            match_n   = 8'd0;
            win_pos_n = 6'd0;
            win_err_n = 7'd0;
          end else if (win_pos == 6'd63) begin
            win_err_n = 7'd0;
          end else begin
            win_err_n = win_err_inc;
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  always_comb begin
    err_cnt_n = err_cnt;
    if (bus.clr_cnt)
      err_cnt_n = 16'd0;
    else if (err_hit && err_cnt != 16'hFFFF)
      err_cnt_n = err_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      sr        <= 7'd0;
      fill      <= 3'd0;
      match     <= 8'd0;
      win_pos   <= 6'd0;
      win_err   <= 7'd0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= 16'd0;
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      fill      <= fill_n;
      match     <= match_n;
      win_pos   <= win_pos_n;
      win_err   <= win_err_n;
      locked    <= (state_n == LOCK);
      err_pulse <= err_hit;
      err_cnt   <= err_cnt_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prbs7_checker.sv
// ---------------------------------------------------------------------
// tb_prbs7_checker : directed self-checking bench for prbs7_checker
// Rev 1.0  initial release
// ---------------------------------------------------------------------
`default_nettype none

module tb_prbs7_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   wpos     = 0;
  logic [6:0] g  = 7'h7F;

  prbs7_if bus ();

  prbs7_checker #(.SYNC_LEN(16), .LOSS_THRESH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic nxt();
    logic b;
    b = g[6] ^ g[5];
    g = {g[5:0], b};
    return b;
  endfunction

  task automatic send(input logic e, input logic d, input logic c);
    @(negedge clk);
    bus.en = e; bus.din = d; bus.clr_cnt = c;
    @(posedge clk);
    #1;
    if (e) wpos++;
  endtask

  task automatic cln();
    send(1'b1, nxt(), 1'b0);
  endtask

  task automatic bad();
    send(1'b1, ~nxt(), 1'b0);
  endtask

  task automatic fill_window();
    repeat (64 - wpos) cln();
    wpos = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.en = 1'b0; bus.din = 1'b0; bus.clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    g = 7'h7F;
    wpos = 0;
  endtask

  initial begin
    bus.en = 1'b0; bus.din = 1'b0; bus.clr_cnt = 1'b0;
    do_reset();
    check("rst_locked", bus.locked, 0);
    check("rst_pulse", bus.err_pulse, 0);
    check("rst_cnt", bus.err_cnt, 0);

    // Clean stream: lock exactly on valid bit 23
    for (int i = 1; i <= 23; i++) begin
      cln();
      check($sformatf("lat_locked_b%0d", i), bus.locked, (i == 23) ? 1 : 0);
      check($sformatf("lat_pulse_b%0d", i), bus.err_pulse, 0);
    end
    check("lat_cnt", bus.err_cnt, 0);
    wpos = 0;

    // Single error
    bad();
    check("one_pulse", bus.err_pulse, 1);
    check("one_cnt", bus.err_cnt, 1);
    check("one_locked", bus.locked, 1);
    cln();
    check("one_pulse_off", bus.err_pulse, 0);
    repeat (10) cln();
    check("one_cnt_hold", bus.err_cnt, 1);
    check("one_locked_hold", bus.locked, 1);

    // Four errors in one window drop lock
    fill_window();
    send(1'b1, nxt(), 1'b1);
    check("clr_cnt", bus.err_cnt, 0);
    bad(); cln(); bad(); cln(); bad();
    check("loss3_locked", bus.locked, 1);
    check("loss3_cnt", bus.err_cnt, 3);
    cln();
    bad();
    check("loss4_pulse", bus.err_pulse, 1);
    check("loss4_cnt", bus.err_cnt, 4);
    check("loss4_locked", bus.locked, 0);
    repeat (22) cln();
    check("relock_b22", bus.locked, 0);
    cln();
    check("relock_b23", bus.locked, 1);
    wpos = 0;

    // Three errors in each of two windows keeps lock
    send(1'b1, nxt(), 1'b1);
    check("clr_cnt2", bus.err_cnt, 0);
    bad(); cln(); bad(); cln(); bad();
    check("winN_cnt", bus.err_cnt, 3);
    fill_window();
    bad(); cln(); bad(); cln(); bad();
    check("winN1_locked", bus.locked, 1);
    check("winN1_cnt", bus.err_cnt, 6);

    // Clear wins over a simultaneous error
    fill_window();
    send(1'b1, ~nxt(), 1'b1);
    check("clrerr_pulse", bus.err_pulse, 1);
    check("clrerr_cnt", bus.err_cnt, 0);
    check("clrerr_locked", bus.locked, 1);

    // en low holds everything
    bad();
    check("en_pre_cnt", bus.err_cnt, 1);
    send(1'b0, 1'b1, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    check("en0_pulse", bus.err_pulse, 0);
    check("en0_cnt", bus.err_cnt, 1);
    check("en0_locked", bus.locked, 1);
    cln();
    check("en0_resume_pulse", bus.err_pulse, 0);
    check("en0_resume_cnt", bus.err_cnt, 1);

    // Reset mid-LOCK beats en and an erroneous bit
    rst = 1'b1;
    send(1'b1, ~nxt(), 1'b0);
    rst = 1'b0;
    check("midrst_locked", bus.locked, 0);
    check("midrst_pulse", bus.err_pulse, 0);
    check("midrst_cnt", bus.err_cnt, 0);

    // All-zero input never leaves HUNT, then clean data locks
    begin
      int pulses = 0;
      int n = 0;
      for (int i = 0; i < 100; i++) begin
        send(1'b1, 1'b0, 1'b0);
        if (bus.locked || bus.err_pulse) pulses++;
      end
      check("zero_activity", pulses, 0);
      check("zero_cnt", bus.err_cnt, 0);
      while (!bus.locked && n < 100) begin
        cln();
        n++;
      end
      check("zero_relock", bus.locked, 1);
      check("zero_relock_cnt", bus.err_cnt, 0);
    end

    // en alternating: lock after 23 valid bits = 45 cycles
    do_reset();
    for (int c = 1; c <= 46; c++) begin
      if (c % 2 == 1) cln();
      else send(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      if (c == 44) check("alt_c44", bus.locked, 0);
      if (c == 45) check("alt_c45", bus.locked, 1);
      if (c == 46) check("alt_c46", bus.locked, 1);
    end
    check("alt_cnt", bus.err_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
